// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer: state encoding, default
// run geometry and counter width helpers.
package bist_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StArmed,
        StInit,
        StRun,
        StGap,
        StCmp,
        StFin,
        StAbt,
        StHold,
        StWait
    } bist_state_e;

    localparam int unsigned DEF_N_PAT       = 9;
    localparam int unsigned DEF_M_ROUNDS    = 40;
    localparam int unsigned DEF_SEED_SWITCH = 13;

    // Counters must be able to hold their terminal value plus one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned DEF_PAT_W   = cnt_width(DEF_N_PAT);
    localparam int unsigned DEF_ROUND_W = cnt_width(DEF_M_ROUNDS);

endpackage

// File: rtl/bist_tc_counter.sv
// Saturating up-counter with synchronous clear and a terminal-count flag
// that is high while the count equals LAST.
module bist_tc_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LAST  = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    // The step taken on the terminal count lands on LAST+1; nothing goes beyond.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count <= LAST_V)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == LAST_V);

endmodule

// File: rtl/bist_sequencer.sv
// BIST run sequencer: arms on a START low-then-high sequence, steps patterns
// and rounds, compares the signature and reports sticky PASS/FAIL/ABORTED.
module bist_sequencer
    import bist_pkg::*;
#(
    parameter int unsigned N_PAT       = DEF_N_PAT,
    parameter int unsigned M_ROUNDS    = DEF_M_ROUNDS,
    parameter int unsigned SEED_SWITCH = DEF_SEED_SWITCH,
    parameter int unsigned NUM_CH      = 4
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              START,
    input  logic                              ABORT,
    input  logic                              SIG_MATCH,
    input  logic [NUM_CH-1:0]                 CH_EN,
    output logic                              RUNNING,
    output logic                              OUT,
    output logic [NUM_CH-1:0]                 CH_OUT,
    output logic                              SEED_SEL,
    output logic                              INIT,
    output logic                              FINISH,
    output logic                              BIST_END,
    output logic                              PASS,
    output logic                              FAIL,
    output logic                              ABORTED,
    output logic [cnt_width(N_PAT)-1:0]       PAT_CNT,
    output logic [cnt_width(M_ROUNDS)-1:0]    ROUND_CNT
);

    localparam int unsigned PAT_W   = cnt_width(N_PAT);
    localparam int unsigned ROUND_W = cnt_width(M_ROUNDS);

    bist_state_e       state_q, state_d;
    logic [NUM_CH-1:0] mask_q;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              aborted_q, aborted_d;
    logic              go, take_abort;
    logic              pat_tc, round_tc;
    logic              pat_clr, pat_en, round_clr, round_en;

    always_comb begin
        state_d    = state_q;
        go         = 1'b0;
        take_abort = 1'b0;
        case (state_q)
            StIdle:  if (!START) state_d = StArmed;
            StArmed: if (START) begin
                state_d = StInit;
                go      = 1'b1;
            end
            StInit: begin
                if (ABORT) begin
                    state_d    = StAbt;
                    take_abort = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (ABORT) begin
                    state_d    = StAbt;
                    take_abort = 1'b1;
                end else if (pat_tc) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (ABORT) begin
                    state_d    = StAbt;
                    take_abort = 1'b1;
                end else if (round_tc) begin
                    state_d = StCmp;
                end else begin
                    state_d = StRun;
                end
            end
            StCmp:   state_d = StFin;
            StFin:   state_d = StHold;
            StAbt:   state_d = StHold;
            StHold:  if (!START) state_d = StWait;
            StWait:  if (START) begin
                state_d = StInit;
                go      = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Counters and flags are cleared on entry to INIT so they read 0 during it.
    assign pat_clr   = go || ((state_q == StGap) && !ABORT);
    assign pat_en    = (state_q == StRun) && !ABORT;
    assign round_clr = go;
    assign round_en  = (state_q == StGap) && !ABORT;

    always_comb begin
        pass_d    = pass_q;
        fail_d    = fail_q;
        aborted_d = aborted_q;
        if (go) begin
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            aborted_d = 1'b0;
        end else if (state_q == StCmp) begin
            pass_d = SIG_MATCH;
            fail_d = !SIG_MATCH;
        end else if (take_abort) begin
            aborted_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= StIdle;
            mask_q    <= '0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            aborted_q <= aborted_d;
            if (state_q == StInit) mask_q <= CH_EN;
        end
    end

    bist_tc_counter #(
        .WIDTH (PAT_W),
        .LAST  (N_PAT - 1)
    ) u_pat_cnt (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (pat_clr),
        .enable (pat_en),
        .count  (PAT_CNT),
        .tc     (pat_tc)
    );

    bist_tc_counter #(
        .WIDTH (ROUND_W),
        .LAST  (M_ROUNDS - 1)
    ) u_round_cnt (
        .CLK    (CLK),
        .RESET  (RESET),
        .clear  (round_clr),
        .enable (round_en),
        .count  (ROUND_CNT),
        .tc     (round_tc)
    );

    always_comb begin
        RUNNING  = 1'b0;
        OUT      = 1'b0;
        SEED_SEL = 1'b0;
        INIT     = 1'b0;
        FINISH   = 1'b0;
        BIST_END = 1'b0;
        PASS     = pass_q;
        FAIL     = fail_q;
        ABORTED  = aborted_q;
        case (state_q)
            StIdle, StArmed: ;
            StInit:  INIT = 1'b1;
            StRun: begin
                RUNNING  = 1'b1;
                OUT      = 1'b1;
                SEED_SEL = (32'(ROUND_CNT) >= SEED_SWITCH);
            end
            StGap:   RUNNING = 1'b1;
            StCmp, StHold, StWait: BIST_END = 1'b1;
            StFin, StAbt: begin
                BIST_END = 1'b1;
                FINISH   = 1'b1;
            end
            default: begin
                PASS    = 1'b0;
                FAIL    = 1'b0;
                ABORTED = 1'b0;
            end
        endcase
    end

    assign CH_OUT = OUT ? mask_q : '0;

endmodule
